// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite slave-side bundle for axil_reg_bank: AW/W/B/AR/R channels.
interface axil_reg_bank_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_bank.sv
// Parametrised AXI4-Lite register bank with byte strobes, read-only status
// registers, per-register write pulses and SLVERR on out-of-range addresses.
module axil_reg_bank #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0]        RO_MASK   = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       aclk,
  input  logic                       areset,
  axil_reg_bank_if.slave             s,
  output logic [NUM_REGS*DATA_W-1:0] ctrl_out,
  input  logic [NUM_REGS*DATA_W-1:0] status_in,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_W - OFF_W;
  localparam int unsigned REG_W  = NUM_REGS * DATA_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  generate
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
      $error("axil_reg_bank: DATA_W must be 32 or 64");
    end
    if (NUM_REGS < 1 || NUM_REGS > 256 || (NUM_REGS * STRB_W) > (2 ** ADDR_W)) begin : g_bad_regs
      $error("axil_reg_bank: NUM_REGS out of range for ADDR_W");
    end
  endgenerate

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e            w_state_q, w_state_d;
  r_state_e            r_state_q, r_state_d;

  logic                aw_held_q, aw_held_d;
  logic                w_held_q,  w_held_d;
  logic [IDX_W-1:0]    w_idx_q,   w_idx_d;
  logic [DATA_W-1:0]   w_data_q,  w_data_d;
  logic [STRB_W-1:0]   w_strb_q,  w_strb_d;
  logic                awready_q, awready_d;
  logic                wready_q,  wready_d;
  logic                bvalid_q,  bvalid_d;
  logic [1:0]          bresp_q,   bresp_d;
  logic [NUM_REGS-1:0] pulse_q,   pulse_d;
  logic [REG_W-1:0]    regs_q,    regs_d;

  logic                ar_held_q, ar_held_d;
  logic [IDX_W-1:0]    r_idx_q,   r_idx_d;
  logic                arready_q, arready_d;
  logic                rvalid_q,  rvalid_d;
  logic [1:0]          rresp_q,   rresp_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;

  logic                w_in_range_c;
  logic                r_in_range_c;

  assign w_in_range_c = (32'(w_idx_q) < NUM_REGS);
  assign r_in_range_c = (32'(r_idx_q) < NUM_REGS);

  // Write path: collect AW and W independently, commit one edge after both are held
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    w_idx_d   = w_idx_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    pulse_d   = '0;
    regs_d    = regs_q;

    case (w_state_q)
      W_IDLE: begin
        if (aw_held_q && w_held_q) begin
          bvalid_d  = 1'b1;
          bresp_d   = w_in_range_c ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (w_in_range_c && (w_idx_q == IDX_W'(i)) && !RO_MASK[i]) begin
              pulse_d[i] = 1'b1;
              for (int b = 0; b < STRB_W; b++) begin
                if (w_strb_q[b]) begin
                  regs_d[i*DATA_W + b*8 +: 8] = w_data_q[b*8 +: 8];
                end
              end
            end
          end
        end else begin
          if (s.awvalid && awready_q) begin
            aw_held_d = 1'b1;
            w_idx_d   = s.awaddr[ADDR_W-1:OFF_W];
          end
          if (s.wvalid && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = s.wdata;
            w_strb_d = s.wstrb;
          end
        end
      end
      W_RESP: begin
        if (s.bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // Read path: capture index on AR, load response one edge later
  always_comb begin
    r_state_d = r_state_q;
    ar_held_d = ar_held_q;
    r_idx_d   = r_idx_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    case (r_state_q)
      R_IDLE: begin
        if (ar_held_q) begin
          ar_held_d = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = r_in_range_c ? RESP_OKAY : RESP_SLVERR;
          rdata_d   = '0;
          r_state_d = R_DATA;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (r_in_range_c && (r_idx_q == IDX_W'(i))) begin
              rdata_d = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W]
                                   : regs_q[i*DATA_W +: DATA_W];
            end
          end
        end else if (s.arvalid && arready_q) begin
          ar_held_d = 1'b1;
          r_idx_d   = s.araddr[ADDR_W-1:OFF_W];
        end
      end
      R_DATA: begin
        if (s.rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    arready_d = (r_state_d == R_IDLE) && !ar_held_d;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      w_idx_q   <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      regs_q    <= RESET_VAL;
      r_state_q <= R_IDLE;
      ar_held_q <= 1'b0;
      r_idx_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      w_idx_q   <= w_idx_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
      r_state_q <= r_state_d;
      ar_held_q <= ar_held_d;
      r_idx_q   <= r_idx_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s.awready = awready_q;
  assign s.wready  = wready_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;
  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rresp   = rresp_q;
  assign s.rdata   = rdata_q;
  assign ctrl_out  = regs_q;
  assign wr_pulse  = pulse_q;

  // Protection bits and sub-word address bits carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{s.awprot, s.arprot, s.awaddr[OFF_W-1:0], s.araddr[OFF_W-1:0]};

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed self-checking bench for axil_reg_bank (DATA_W=32, NUM_REGS=8, reg1 read-only).
module tb_axil_reg_bank;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned NR = 8;
  localparam logic [NR-1:0]    RO = 8'b0000_0010;
  localparam logic [NR*DW-1:0] RV = {32'h0, 32'h0, 32'h55AA0005, 32'h0,
                                     32'h0, 32'h0, 32'h11110001, 32'h0};

  logic             aclk;
  logic             areset;
  logic [NR*DW-1:0] ctrl_out;
  logic [NR*DW-1:0] status_in;
  logic [NR-1:0]    wr_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt [NR];

  axil_reg_bank_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

  axil_reg_bank #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RV)
  ) dut (
    .aclk(aclk), .areset(areset), .s(s_if.slave),
    .ctrl_out(ctrl_out), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
  always @(negedge aclk) begin
    for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs;
    @(negedge aclk);
    s_if.awaddr = addr; s_if.awvalid = 1'b1;
    s_if.wdata = data; s_if.wstrb = strb; s_if.wvalid = 1'b1;
    n = 0;
    while ((s_if.awvalid || s_if.wvalid) && n < 50) begin
      aw_hs = s_if.awvalid && s_if.awready;
      w_hs  = s_if.wvalid && s_if.wready;
      @(negedge aclk);
      if (aw_hs) s_if.awvalid = 1'b0;
      if (w_hs)  s_if.wvalid = 1'b0;
      n++;
    end
    s_if.bready = 1'b1;
    while (!s_if.bvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    chk("wr_done_in_time", 64'(n < 50), 64'd1);
    resp = s_if.bresp;
    @(negedge aclk);
    s_if.bready = 1'b0; s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    int n;
    logic hs;
    @(negedge aclk);
    s_if.araddr = addr; s_if.arvalid = 1'b1;
    n = 0;
    while (s_if.arvalid && n < 50) begin
      hs = s_if.arready;
      @(negedge aclk);
      if (hs) s_if.arvalid = 1'b0;
      n++;
    end
    s_if.rready = 1'b1;
    while (!s_if.rvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    chk("rd_done_in_time", 64'(n < 50), 64'd1);
    data = s_if.rdata;
    resp = s_if.rresp;
    @(negedge aclk);
    s_if.rready = 1'b0; s_if.arvalid = 1'b0;
  endtask

  task automatic chk_regs_reset();
    for (int i = 0; i < NR; i++)
      chk($sformatf("ctrl_reset_r%0d", i), 64'(ctrl_out[i*DW +: DW]), 64'(RV[i*DW +: DW]));
  endtask

  logic [DW-1:0] rd;
  logic [1:0]    rsp;
  int            n;

  initial begin
    areset = 1'b1;
    s_if.awaddr = '0; s_if.awprot = '0; s_if.awvalid = 1'b0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wvalid = 1'b0; s_if.bready = 1'b0;
    s_if.araddr = '0; s_if.arprot = '0; s_if.arvalid = 1'b0; s_if.rready = 1'b0;
    status_in = {NR{32'hBAD0BAD0}};
    status_in[63:32] = 32'hCAFEF00D;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_awready", 64'(s_if.awready), 64'd0);
    chk("rst_arready", 64'(s_if.arready), 64'd0);
    chk("rst_bvalid", 64'(s_if.bvalid), 64'd0);
    chk("rst_rvalid", 64'(s_if.rvalid), 64'd0);
    chk("rst_rdata", 64'(s_if.rdata), 64'd0);
    chk("rst_wr_pulse", 64'(wr_pulse), 64'd0);
    chk_regs_reset();
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_awready", 64'(s_if.awready), 64'd1);
    chk("post_rst_wready", 64'(s_if.wready), 64'd1);
    chk("post_rst_arready", 64'(s_if.arready), 64'd1);

    // Basic RW
    axi_write(12'h000, 32'hDEADBEEF, 4'hF, rsp); chk("w0_resp", 64'(rsp), 64'd0);
    axi_write(12'h004 + 12'h010, 32'h00000001, 4'hF, rsp); chk("w4_resp", 64'(rsp), 64'd0);
    axi_write(12'h008, 32'h00000002, 4'hF, rsp); chk("w8_resp", 64'(rsp), 64'd0);
    axi_write(12'h004, 32'h00000001, 4'hF, rsp); chk("w4ro_resp", 64'(rsp), 64'd0);
    axi_read(12'h000, rd, rsp); chk("r0_data", 64'(rd), 64'hDEADBEEF); chk("r0_resp", 64'(rsp), 64'd0);
    axi_read(12'h014, rd, rsp); chk("r14_data", 64'(rd), 64'h00000001);
    axi_read(12'h00B, rd, rsp); chk("r8_data_offset_ignored", 64'(rd), 64'h00000002);
    chk("pulse0_once", 64'(pulse_cnt[0]), 64'd1);
    chk("pulse5_once", 64'(pulse_cnt[5]), 64'd1);
    chk("pulse2_once", 64'(pulse_cnt[2]), 64'd1);
    chk("pulse1_ro_none", 64'(pulse_cnt[1]), 64'd0);

    // Byte strobes
    axi_write(12'h000, 32'h11223344, 4'b0101, rsp);
    axi_read(12'h000, rd, rsp); chk("strb_data", 64'(rd), 64'hDE22BE44);
    chk("strb_ctrl", 64'(ctrl_out[31:0]), 64'hDE22BE44);
    axi_write(12'h000, 32'hFFFFFFFF, 4'b0000, rsp); chk("strb0_resp", 64'(rsp), 64'd0);
    chk("strb0_pulse", 64'(pulse_cnt[0]), 64'd3);
    chk("strb0_ctrl", 64'(ctrl_out[31:0]), 64'hDE22BE44);

    // W before AW, then B backpressure
    @(negedge aclk);
    s_if.wdata = 32'h000000F0; s_if.wstrb = 4'hF; s_if.wvalid = 1'b1;
    @(negedge aclk);
    s_if.wvalid = 1'b0;
    chk("ord_wready_held", 64'(s_if.wready), 64'd0);
    chk("ord_awready_idle", 64'(s_if.awready), 64'd1);
    @(negedge aclk);
    @(negedge aclk);
    s_if.awaddr = 12'h00C; s_if.awvalid = 1'b1;
    @(negedge aclk);
    s_if.awvalid = 1'b0;
    chk("ord_bvalid_early", 64'(s_if.bvalid), 64'd0);
    @(negedge aclk);
    s_if.awaddr = 12'h010; s_if.awvalid = 1'b1;
    s_if.wdata = 32'h00000077; s_if.wvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_bvalid_%0d", k), 64'(s_if.bvalid), 64'd1);
      chk($sformatf("bp_readies_%0d", k), 64'({s_if.awready, s_if.wready}), 64'd0);
      @(negedge aclk);
    end
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    chk("bp_ctrl_r3", 64'(ctrl_out[127:96]), 64'h000000F0);
    chk("bp_ctrl_r4", 64'(ctrl_out[159:128]), 64'h0);
    s_if.bready = 1'b1;
    @(negedge aclk);
    s_if.bready = 1'b0;
    chk("bp_bvalid_done", 64'(s_if.bvalid), 64'd0);
    chk("bp_awready_back", 64'(s_if.awready), 64'd1);
    axi_read(12'h00C, rd, rsp); chk("ord_rd", 64'(rd), 64'h000000F0);

    // Read-only register and out-of-range
    axi_write(12'h004, 32'h12345678, 4'hF, rsp); chk("ro_wresp", 64'(rsp), 64'd0);
    axi_read(12'h004, rd, rsp); chk("ro_rdata", 64'(rd), 64'hCAFEF00D);
    chk("ro_ctrl", 64'(ctrl_out[63:32]), 64'h11110001);
    chk("ro_pulse", 64'(pulse_cnt[1]), 64'd0);
    axi_write(12'h020, 32'h99999999, 4'hF, rsp); chk("oor_wresp", 64'(rsp), 64'd2);
    axi_read(12'h020, rd, rsp); chk("oor_rdata", 64'(rd), 64'd0); chk("oor_rresp", 64'(rsp), 64'd2);
    n = 0;
    for (int i = 0; i < NR; i++) n += pulse_cnt[i];
    chk("oor_pulse_total", 64'(n), 64'd6);

    // Write commit and read load on the same edge for reg2
    @(negedge aclk);
    s_if.awaddr = 12'h008; s_if.awvalid = 1'b1;
    s_if.wdata = 32'hAAAAAAAA; s_if.wstrb = 4'hF; s_if.wvalid = 1'b1;
    s_if.araddr = 12'h008; s_if.arvalid = 1'b1;
    @(negedge aclk);
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
    @(negedge aclk);
    chk("col_rvalid", 64'(s_if.rvalid), 64'd1);
    chk("col_bvalid", 64'(s_if.bvalid), 64'd1);
    chk("col_rdata_old", 64'(s_if.rdata), 64'h00000002);
    s_if.rready = 1'b1; s_if.bready = 1'b1;
    @(negedge aclk);
    s_if.rready = 1'b0; s_if.bready = 1'b0;
    axi_read(12'h008, rd, rsp); chk("col_rdata_new", 64'(rd), 64'hAAAAAAAA);

    // Reset while B and R are both pending
    @(negedge aclk);
    s_if.awaddr = 12'h000; s_if.awvalid = 1'b1;
    s_if.wdata = 32'h00000012; s_if.wvalid = 1'b1;
    s_if.araddr = 12'h008; s_if.arvalid = 1'b1;
    @(negedge aclk);
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
    n = 0;
    while (!(s_if.bvalid && s_if.rvalid) && n < 10) begin
      @(negedge aclk);
      n++;
    end
    chk("mid_both_pending", 64'({s_if.bvalid, s_if.rvalid}), 64'd3);
    areset = 1'b1;
    @(negedge aclk);
    chk("mid_valids_cleared", 64'({s_if.bvalid, s_if.rvalid}), 64'd0);
    chk("mid_readies_low", 64'({s_if.awready, s_if.wready, s_if.arready}), 64'd0);
    chk("mid_rdata", 64'(s_if.rdata), 64'd0);
    chk_regs_reset();
    areset = 1'b0;
    @(negedge aclk);
    chk("mid_readies_back", 64'({s_if.awready, s_if.wready, s_if.arready}), 64'd7);
    s_if.bready = 1'b1; s_if.rready = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      chk("mid_no_beat", 64'({s_if.bvalid, s_if.rvalid}), 64'd0);
    end
    s_if.bready = 1'b0; s_if.rready = 1'b0;
    axi_read(12'h014, rd, rsp); chk("mid_r5_resetval", 64'(rd), 64'h55AA0005);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
